store_buffer: RTL

Four-entry posted-write buffer between the core's store path and the data memory port. It accepts store requests carrying the raw register value and funct3, and formats each request into a word-aligned address, lane-replicated write data and a 4-bit byte enable. It drains entries in order over a valid/ready handshake and flags loads that hit a pending store's word. A fence sequencer lets the core wait until every posted store has been written.

---
 rtl/store_buffer_pkg.sv | 17 +
 rtl/store_lane_fmt.sv | 38 +++
 rtl/store_buffer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
// Shared store-path definitions: bus widths, store funct3 codes and fence sequencer states.
package store_buffer_pkg;

  localparam int unsigned DATA_BUS_BITS = 32;
  localparam int unsigned BE_BITS       = 4;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    SBF_IDLE  = 2'd0,
    SBF_DRAIN = 2'd1,
    SBF_DONE  = 2'd2
  } sbf_state_e;

endpackage

// File: rtl/store_lane_fmt.sv
// Combinational store formatter: lane-replicated write data, byte enables and misalignment flag.
module store_lane_fmt
  import store_buffer_pkg::*;
#(
  parameter int unsigned DW = DATA_BUS_BITS
) (
  input  logic [1:0]         addr,
  input  logic [2:0]         funct3,
  input  logic [DW-1:0]      data,
  output logic [DW-1:0]      wdata,
  output logic [BE_BITS-1:0] be,
  output logic               err
);

  always_comb begin
    wdata = '0;
    be    = '0;
    err   = 1'b0;
    case (funct3)
      F3_SB: begin
        be    = BE_BITS'(1) << addr;
        wdata = {(DW/8){data[7:0]}};
      end
      F3_SH: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {(DW/16){data[15:0]}};
        err   = addr[0];
      end
      F3_SW: begin
        be    = '1;
        wdata = data;
        err   = (addr != 2'b00);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: formats stores, drains them in order to memory,
// flags load hazards against pending words and sequences fence drains.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = DATA_BUS_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  input  logic [2:0]               st_funct3,
  output logic                     misalign_err,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  output logic [BE_BITS-1:0]       mem_be,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_hazard,
  input  logic                     fence,
  output logic                     fence_done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned WAW = AW - 2;

  typedef struct packed {
    logic [WAW-1:0]     waddr;
    logic [DW-1:0]      wdata;
    logic [BE_BITS-1:0] be;
  } sb_entry_t;

  sb_entry_t        ent_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             err_q;
  sbf_state_e       state_q, state_d;

  logic [DW-1:0]      fmt_wdata;
  logic [BE_BITS-1:0] fmt_be;
  logic               fmt_err;
  logic               full, accept, push, pop, idle_c, done_c;
  logic               unused_ld_lo;

  store_lane_fmt #(.DW(DW)) u_fmt (
    .addr   (st_addr[1:0]),
    .funct3 (st_funct3),
    .data   (st_data),
    .wdata  (fmt_wdata),
    .be     (fmt_be),
    .err    (fmt_err)
  );

  // Fence sequencer next state and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    idle_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      SBF_IDLE: begin
        idle_c = 1'b1;
        if (fence) state_d = SBF_DRAIN;
      end
      SBF_DRAIN: if (cnt_q == '0) state_d = SBF_DONE;
      SBF_DONE: begin
        done_c  = 1'b1;
        state_d = SBF_IDLE;
      end
      default: state_d = SBF_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SBF_IDLE;
    else     state_q <= state_d;
  end

  // No bypass: a full buffer refuses stores even while the head drains.
  assign full     = (cnt_q == CW'(DEPTH));
  assign st_ready = !rst && !full && idle_c;
  assign accept   = st_valid && st_ready;
  assign push     = accept && !fmt_err;
  assign pop      = mem_valid && mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      err_q <= accept && fmt_err;
      if (push) begin
        ent_q[wptr_q] <= '{waddr: st_addr[AW-1:2], wdata: fmt_wdata, be: fmt_be};
        vld_q[wptr_q] <= 1'b1;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop) begin
        vld_q[rptr_q] <= 1'b0;
        rptr_q        <= rptr_q + PW'(1);
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Word-granular hazard; the head still counts while it is being dequeued.
  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (ent_q[i].waddr == ld_addr[AW-1:2])) ld_hazard = 1'b1;
    end
  end

  assign unused_ld_lo = ^ld_addr[1:0];

  assign mem_valid    = (cnt_q != '0);
  assign mem_addr     = {ent_q[rptr_q].waddr, 2'b00};
  assign mem_wdata    = ent_q[rptr_q].wdata;
  assign mem_be       = ent_q[rptr_q].be;
  assign misalign_err = err_q;
  assign fence_done   = done_c;
  assign count        = cnt_q;

endmodule
